// File: rtl/vmem_local_dma.sv
// vmem_local_dma: single-channel DMA between a valid/ready row stream and
// port B of a vmem_local lane memory. A command moves row_count rows starting
// at base_addr, either filling memory from in_* or draining memory to out_*.
//
// Optional feature: define VMEM_DMA_STRIDE_EN to add the row_stride port
// (latched at start). Without it the row pointer steps by one row.
//
// Port-B reads have a fixed 1-cycle latency. Drained rows land in a 2-entry
// FIFO. Reads are only issued while FIFO occupancy plus reads still in flight
// stays below two, so the FIFO cannot overflow for any out_ready pattern.
module vmem_local_dma #(
    parameter int NUMLANES     = 8,
    parameter int DATAWORDSIZE = 16,
    parameter int MEMDEPTH     = 2048,
    parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH)
) (
    input  logic                                 clk,
    input  logic                                 reset,

    // command interface
    input  logic                                 start,
    input  logic                                 dir,
    input  logic [LOGMEMDEPTH-1:0]               base_addr,
    input  logic [LOGMEMDEPTH:0]                 row_count,
`ifdef VMEM_DMA_STRIDE_EN
    input  logic [LOGMEMDEPTH-1:0]               row_stride,
`endif
    output logic                                 busy,
    output logic                                 done,

    // fill stream (stream -> memory)
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUMLANES*DATAWORDSIZE-1:0]     in_data,

    // drain stream (memory -> stream)
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUMLANES*DATAWORDSIZE-1:0]     out_data,

    // vmem_local port B
    output logic [NUMLANES*LOGMEMDEPTH-1:0]      address_b,
    output logic                                 rden_b,
    output logic                                 wren_b,
    output logic [NUMLANES*DATAWORDSIZE-1:0]     data_b,
    input  logic [NUMLANES*DATAWORDSIZE-1:0]     out_b
);

    localparam int                     ROWW      = NUMLANES * DATAWORDSIZE;
    localparam logic [LOGMEMDEPTH+1:0] DEPTH_EXT = (LOGMEMDEPTH+2)'(MEMDEPTH);
    localparam logic [LOGMEMDEPTH:0]   CNT_ONE   = (LOGMEMDEPTH+1)'(1);
    localparam logic [LOGMEMDEPTH:0]   CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [LOGMEMDEPTH-1:0] row_ptr;      // row of the next port-B access
    logic [LOGMEMDEPTH:0]   rows_left;    // accesses not yet issued
    logic [LOGMEMDEPTH:0]   beats_left;   // drain beats not yet delivered
    logic [LOGMEMDEPTH-1:0] step;
    logic [LOGMEMDEPTH-1:0] row_next;

    // drain FIFO and read pipeline
    logic [ROWW-1:0]        fifo_mem [2];
    logic                   fifo_wr_ptr;
    logic                   fifo_rd_ptr;
    logic [1:0]             fifo_cnt;
    logic                   rd_pend;      // a read was issued last cycle; out_b is valid now
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [2:0]             committed;    // FIFO slots spoken for after this edge
    logic                   can_read;

`ifdef VMEM_DMA_STRIDE_EN
    logic [LOGMEMDEPTH-1:0] stride_q;
    assign step = stride_q;
`else
    assign step = LOGMEMDEPTH'(1);
`endif

    // Row increment modulo MEMDEPTH; handles non-power-of-two depths and
    // strides up to the full address range.
    function automatic logic [LOGMEMDEPTH-1:0] wrap_add(
        input logic [LOGMEMDEPTH-1:0] a,
        input logic [LOGMEMDEPTH-1:0] b
    );
        logic [LOGMEMDEPTH+1:0] sum;
        sum = {2'b00, a} + {2'b00, b};
        if (sum >= DEPTH_EXT) sum = sum - DEPTH_EXT;
        if (sum >= DEPTH_EXT) sum = sum - DEPTH_EXT;
        return sum[LOGMEMDEPTH-1:0];
    endfunction

    assign row_next  = wrap_add(row_ptr, step);
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_mem[fifo_rd_ptr];
    assign fifo_push = rd_pend;
    assign fifo_pop  = out_valid & out_ready;

    // Decide whether a new read may be issued next cycle: count what the FIFO
    // will hold after this edge plus the read currently on port B.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise
        // synthesis infers a latch to hold the old value.
        committed = '0;
        can_read  = 1'b0;
        committed = 3'(fifo_cnt) + 3'(fifo_push) + 3'(rden_b) - 3'(fifo_pop);
        can_read  = (state == ST_DRAIN) && (rows_left != CNT_ZERO) && (committed < 3'd2);
    end

    // Drain FIFO: captures out_b one cycle after each read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the two FIFO entries are reset because out_data is
            // visible directly from storage and must read zero after reset.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
            rd_pend     <= 1'b0;
        end else begin
            rd_pend <= rden_b;
            if (fifo_push) begin
                fifo_mem[fifo_wr_ptr] <= out_b;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    // Transfer FSM with registered port-B strobes and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            state      <= ST_IDLE;
            row_ptr    <= '0;
            rows_left  <= '0;
            beats_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            rden_b     <= 1'b0;
            wren_b     <= 1'b0;
            address_b  <= '0;
            data_b     <= '0;
`ifdef VMEM_DMA_STRIDE_EN
            stride_q   <= '0;
`endif
        end else begin
            // strobes and the done pulse are single-cycle unless re-asserted
            rden_b <= 1'b0;
            wren_b <= 1'b0;
            done   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        row_ptr    <= base_addr;
                        rows_left  <= row_count;
                        beats_left <= row_count;
`ifdef VMEM_DMA_STRIDE_EN
                        stride_q   <= row_stride;
`endif
                        if (row_count == CNT_ZERO) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (dir) begin
                            state <= ST_DRAIN;
                        end else begin
                            state    <= ST_FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (in_valid && in_ready) begin
                        wren_b    <= 1'b1;
                        data_b    <= in_data;
                        address_b <= {NUMLANES{row_ptr}};
                        row_ptr   <= row_next;
                        rows_left <= rows_left - CNT_ONE;
                        if (rows_left == CNT_ONE) begin
                            in_ready <= 1'b0;
                        end
                    end else if (wren_b && (rows_left == CNT_ZERO)) begin
                        // the last write strobe is on port B this cycle
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (can_read) begin
                        rden_b    <= 1'b1;
                        address_b <= {NUMLANES{row_ptr}};
                        row_ptr   <= row_next;
                        rows_left <= rows_left - CNT_ONE;
                    end
                    if (fifo_pop) begin
                        beats_left <= beats_left - CNT_ONE;
                        if (beats_left == CNT_ONE) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_local_dma.sv
// tb_vmem_local_dma: directed bench for vmem_local_dma with a behavioural
// port-B memory (1-cycle read latency). Table-driven transfers plus
// hand-written sequences for reset state and mid-transfer reset.
module tb_vmem_local_dma;

  localparam int NL = 8;
  localparam int DW = 16;
  localparam int MD = 2048;
  localparam int AW = 11;
  localparam int W  = NL * DW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              dir;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       row_count;
`ifdef VMEM_DMA_STRIDE_EN
  logic [AW-1:0]     row_stride;
`endif
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [NL*AW-1:0]  address_b;
  logic              rden_b;
  logic              wren_b;
  logic [W-1:0]      data_b;
  logic [W-1:0]      out_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vmem_local_dma dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .base_addr  (base_addr),
    .row_count  (row_count),
`ifdef VMEM_DMA_STRIDE_EN
    .row_stride (row_stride),
`endif
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .address_b  (address_b),
    .rden_b     (rden_b),
    .wren_b     (wren_b),
    .data_b     (data_b),
    .out_b      (out_b)
  );

  // ---------------- port-B memory model ----------------
  logic [W-1:0] mem [MD];
  bit           written [MD];
  logic [AW-1:0] row;
  assign row = address_b[AW-1:0];

  // preloaded contents of every row that has not been written
  function automatic logic [W-1:0] init_pat(input int r);
    logic [W-1:0] v;
    for (int j = 0; j < NL; j++) v[j*DW +: DW] = DW'(32'h1000 + r * NL + j);
    return v;
  endfunction

  function automatic logic [W-1:0] fill_pat(input int tag, input int i);
    logic [W-1:0] v;
    for (int j = 0; j < NL; j++) v[j*DW +: DW] = DW'(32'hC000 + tag * 64 + i * 8 + j);
    return v;
  endfunction

  function automatic logic [W-1:0] mem_rd(input int r);
    return written[r] ? mem[r] : init_pat(r);
  endfunction

  always @(posedge clk) begin
    if (wren_b) begin
      mem[row]     <= data_b;
      written[row] <= 1'b1;
    end
    if (rden_b) out_b <= mem_rd(int'(row));
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},      W'(busy),      '0);
    check({tag, " done"},      W'(done),      '0);
    check({tag, " in_ready"},  W'(in_ready),  '0);
    check({tag, " out_valid"}, W'(out_valid), '0);
    check({tag, " rden_b"},    W'(rden_b),    '0);
    check({tag, " wren_b"},    W'(wren_b),    '0);
    check({tag, " address_b"}, W'(address_b), '0);
    check({tag, " data_b"},    data_b,        '0);
    check({tag, " out_data"},  out_data,      '0);
  endtask

  typedef struct {
    logic       dir;
    int         base;
    int         count;
    logic [3:0] rdy;          // out_ready pattern, bit k%4 in cycle k
    int         stride;
    int         exp_last;     // row of the last strobe
    int         exp_strobes;  // port-B strobes of the requested kind
    int         exp_done_k;   // cycle (after start edge) of done, -1 = not fixed
    int         glitch_k;     // cycle to pulse an extra start, -1 = none
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v, input int tag);
    int   strobe_rows[$];
    int   strobe_k[$];
    logic [W-1:0] beats[$];
    int   issued = 0, delivered = 0, wren_cnt = 0, rden_cnt = 0;
    int   occ_viol = 0, both_viol = 0, addr_viol = 0;
    int   done_cnt = 0, done_k = -1, beat_i = 0;
    int   row_err = 0, data_err = 0, tim_err = 0, exp_row;
    bit   finished = 0;
    logic acc;

    @(posedge clk); #1;
    start     = 1'b1;
    dir       = v.dir;
    base_addr = AW'(v.base);
    row_count = (AW+1)'(v.count);
`ifdef VMEM_DMA_STRIDE_EN
    row_stride = AW'(v.stride);
`endif
    in_valid  = !v.dir;
    in_data   = fill_pat(tag, 0);
    out_ready = v.rdy[0];
    @(posedge clk); #1;
    start = 1'b0;

    for (int k = 0; k < 400 && !finished; k++) begin
      @(negedge clk);
      if (wren_b && rden_b) both_viol++;
      if (wren_b || rden_b) begin
        if (address_b != {NL{address_b[AW-1:0]}}) addr_viol++;
        strobe_rows.push_back(int'(address_b[AW-1:0]));
        strobe_k.push_back(k);
      end
      if (wren_b) wren_cnt++;
      if (rden_b) begin
        rden_cnt++;
        issued++;
      end
      if (issued - delivered > 2) occ_viol++;
      if (out_valid && out_ready) begin
        beats.push_back(out_data);
        delivered++;
      end
      acc = in_valid && in_ready;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 2) finished = 1;
      @(posedge clk); #1;
      if (acc) begin
        beat_i++;
        in_data = fill_pat(tag, beat_i);
      end
      out_ready = v.rdy[(k + 1) % 4];
      start = (k == v.glitch_k);
      if (k == v.glitch_k) begin
        dir       = ~v.dir;
        base_addr = AW'(900);
        row_count = (AW+1)'(3);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;

    check($sformatf("v%0d done pulses", tag), W'(done_cnt), W'(1));
    if (v.exp_done_k >= 0) check($sformatf("v%0d done cycle", tag), W'(done_k), W'(v.exp_done_k));
    check($sformatf("v%0d busy after done", tag), W'(busy), '0);
    check($sformatf("v%0d strobe count", tag), W'(v.dir ? rden_cnt : wren_cnt), W'(v.exp_strobes));
    check($sformatf("v%0d wrong-kind strobes", tag), W'(v.dir ? wren_cnt : rden_cnt), '0);
    check($sformatf("v%0d rden&wren together", tag), W'(both_viol), '0);
    check($sformatf("v%0d address lanes differ", tag), W'(addr_viol), '0);
    if (v.exp_strobes > 0) begin
      check($sformatf("v%0d first row", tag), W'(strobe_rows[0]), W'(v.base));
      check($sformatf("v%0d last row", tag), W'(strobe_rows[strobe_rows.size()-1]), W'(v.exp_last));
    end
    for (int i = 0; i < strobe_rows.size(); i++) begin
      exp_row = (v.base + i * v.stride) % MD;
      if (strobe_rows[i] != exp_row) row_err++;
      if (!v.dir && mem_rd(exp_row) !== fill_pat(tag, i)) data_err++;
      if (!v.dir && strobe_k[i] != i + 1) tim_err++;
    end
    if (v.dir) begin
      check($sformatf("v%0d beats delivered", tag), W'(beats.size()), W'(v.count));
      check($sformatf("v%0d occupancy over 2", tag), W'(occ_viol), '0);
      for (int i = 0; i < beats.size(); i++) begin
        exp_row = (v.base + i * v.stride) % MD;
        if (beats[i] !== mem_rd(exp_row)) data_err++;
      end
    end else begin
      check($sformatf("v%0d write cycles not consecutive", tag), W'(tim_err), '0);
    end
    check($sformatf("v%0d row order errors", tag), W'(row_err), '0);
    check($sformatf("v%0d data errors", tag), W'(data_err), '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wr_seen;
    int beat;
    int late_wren;
    logic acc;

    reset     = 1'b1;
    start     = 1'b0;
    dir       = 1'b0;
    base_addr = '0;
    row_count = '0;
`ifdef VMEM_DMA_STRIDE_EN
    row_stride = '0;
`endif
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    //                 dir   base  cnt  rdy      strd last strb done glitch
    vecs.push_back(vec_t'{1'b0, 5,    3, 4'b1111, 1,   7,   3,   4,  -1});
    vecs.push_back(vec_t'{1'b1, 2046, 4, 4'b1111, 1,   1,   4,  -1,  -1});
    vecs.push_back(vec_t'{1'b1, 10,   6, 4'b1001, 1,   15,  6,  -1,  -1});
    vecs.push_back(vec_t'{1'b0, 2046, 3, 4'b1111, 1,   0,   3,   4,  -1});
    vecs.push_back(vec_t'{1'b0, 40,   0, 4'b1111, 1,   0,   0,   0,  -1});
    vecs.push_back(vec_t'{1'b1, 7,    0, 4'b1111, 1,   0,   0,   0,  -1});
    vecs.push_back(vec_t'{1'b1, 300,  1, 4'b0101, 1,   300, 1,  -1,  -1});
    vecs.push_back(vec_t'{1'b1, 500,  4, 4'b1111, 1,   503, 4,  -1,   1});
`ifdef VMEM_DMA_STRIDE_EN
    vecs.push_back(vec_t'{1'b0, 0,    3, 4'b1111, 8,   16,  3,   4,  -1});
`endif

    for (int t = 0; t < vecs.size(); t++) run_vec(vecs[t], t);

    // mid-transfer reset: fill rows 100..104, abort after two writes
    @(posedge clk); #1;
    start     = 1'b1;
    dir       = 1'b0;
    base_addr = AW'(100);
    row_count = (AW+1)'(5);
`ifdef VMEM_DMA_STRIDE_EN
    row_stride = AW'(1);
`endif
    in_valid  = 1'b1;
    beat      = 0;
    in_data   = fill_pat(20, 0);
    @(posedge clk); #1;
    start   = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 50 && wr_seen < 2; k++) begin
      @(negedge clk);
      if (wren_b) wr_seen++;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        beat++;
        in_data = fill_pat(20, beat);
      end
    end
    check("abort writes before reset", W'(wr_seen), W'(2));
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    late_wren = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wren_b || rden_b || busy) late_wren++;
    end
    check("strobes after abort", W'(late_wren), '0);
    check("abort row 100 data", mem_rd(100), fill_pat(20, 0));
    check("abort row 101 data", mem_rd(101), fill_pat(20, 1));
    check("abort row 102 untouched", W'(written[102]), '0);
    check("abort row 103 untouched", W'(written[103]), '0);
    check("abort row 104 untouched", W'(written[104]), '0);

    // recovery after the abort
    run_vec(vec_t'{1'b0, 200, 2, 4'b1111, 1, 201, 2, 3, -1}, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_local_dma.md
VMEM_LOCAL_DMA -- requirements
Module: vmem_local_dma

Interface
REQ-001 SHALL take parameter NUMLANES, default 8, lanes per memory row.
REQ-002 SHALL take parameter DATAWORDSIZE, default 16, bits per lane word.
REQ-003 SHALL take parameter MEMDEPTH, default 2048, rows per lane memory.
REQ-004 SHALL take parameter LOGMEMDEPTH, default $clog2(MEMDEPTH), row address width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: ports clk and reset.
REQ-006 clk  input  1  block clock, rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 start  input  1  command strobe, sampled only in IDLE.
REQ-009 dir  input  1  0 = fill (stream to memory), 1 = drain (memory to stream).
REQ-010 base_addr  input  LOGMEMDEPTH  first row.
REQ-011 row_count  input  LOGMEMDEPTH+1  rows to move; 0 is legal.
REQ-012 row_stride  input  LOGMEMDEPTH  row increment; present only with VMEM_DMA_STRIDE_EN.
REQ-013 busy  output  1  high outside IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 in_valid / in_ready / in_data  input / output / NUMLANES*DATAWORDSIZE  fill stream.
REQ-016 out_valid / out_ready / out_data  output / input / NUMLANES*DATAWORDSIZE  drain stream.
REQ-017 address_b  output  NUMLANES*LOGMEMDEPTH  current row replicated into every lane field.
REQ-018 rden_b, wren_b  output  1 each  vmem_local port-B strobes.
REQ-019 data_b  output  NUMLANES*DATAWORDSIZE  write data; out_b  input  same width, read data.

Function
REQ-020 SHALL implement states IDLE, FILL, DRAIN, DONE.
REQ-021 IDLE & start: latch base, count and dir; go FILL (dir=0) or DRAIN (dir=1); if row_count=0, go straight to DONE.
REQ-022 Ignore start outside IDLE.
REQ-023 FILL: in_ready=1 while rows remain; each accepted beat (in_valid&in_ready) SHALL, next cycle, drive wren_b=1 for exactly one cycle with data_b=accepted beat and address_b=current row.
REQ-024 After the last write strobe, FILL SHALL go DONE; in_ready=0 once the final beat has been accepted.
REQ-025 DRAIN: port-B read latency is exactly 1 cycle (out_b valid the cycle after rden_b); read data SHALL enter a 2-entry FIFO driving out_data/out_valid.
REQ-026 rden_b SHALL assert only while rows remain and (FIFO occupancy + reads in flight) < 2; FIFO SHALL never overflow under any out_ready pattern.
REQ-027 Beat delivered on out_valid&out_ready; beats in row order, no duplicates or drops.
REQ-028 DRAIN SHALL go DONE when the last beat is delivered.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 Row pointer advances by step per issued access, modulo MEMDEPTH (wrap from MEMDEPTH-1 to 0).
REQ-031 rden_b and wren_b SHALL never be high together; both low in IDLE and DONE.
REQ-032 rden_b, wren_b, address_b and data_b SHALL be registered outputs.

Reset
REQ-033 On reset: state IDLE; busy, done, in_ready, out_valid, rden_b and wren_b =0; address_b, data_b, out_data =0; FIFO empty.
REQ-034 Reset mid-transfer SHALL abort immediately with no further strobes; memory rows already written remain, remaining rows are untouched.

Configuration
REQ-035 With VMEM_DMA_STRIDE_EN defined: row_stride port exists, latched at start, step = row_stride (0 repeats the same row).
REQ-036 Without VMEM_DMA_STRIDE_EN: no row_stride port, step = 1.

Verification
REQ-037 Fill base=5, count=3, in_valid held high -> wren_b rows 5,6,7 on consecutive cycles, then done pulse; busy low after.
REQ-038 Drain base=2046, count=4, out_ready=1 -> reads rows 2046,2047,0,1; out_data matches preloaded contents in order.
REQ-039 Drain count=6 with out_ready toggling 1-0-0-1 -> no overflow, occupancy+in-flight <= 2, six beats in order.
REQ-040 start with count=0 -> done one cycle later, no strobes; second start while busy -> ignored.
REQ-041 Reset asserted after 2 of 5 fill writes -> all outputs 0 that cycle; rows 2-4 unchanged.
REQ-042 With VMEM_DMA_STRIDE_EN, fill base=0, stride=8, count=3 -> writes rows 0,8,16.
